// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multicycle MIPS subset core with a single req/ready memory port
module mips_multicycle #(
    parameter logic [31:0] PC_RESET     = 32'h0000_0000,
    parameter int          MEM_ADDR_W   = 32,
    parameter int          MEM_WAIT_MAX = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc,
    output logic [31:0]           ula_result,
    output logic [31:0]           data_mem,
    output logic                  halted,
    output logic [1:0]            fault
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_ALIGN   = 2'b10;
    localparam logic [1:0] FAULT_BUS     = 2'b11;

    localparam int WAIT_W      = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam int WAIT_LAST_I = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_I[WAIT_W-1:0];

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t              state;
    state_t              next_state;
    logic [1:0]          next_fault;
    logic                started;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [31:0]         ir;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    logic [31:0]         rf [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] pc_plus4;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] alu_y;
    logic [4:0]  wr_idx;
    logic [31:0] wb_data;
    logic        op_legal;
    logic        mem_accept;
    logic        wait_expired;

    assign opcode    = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign funct     = ir[5:0];
    assign imm_sext  = {{16{ir[15]}}, ir[15:0]};
    assign pc_plus4  = pc + 32'd4;
    assign branch_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_pc   = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign wr_idx    = (opcode == OP_R) ? rd : rt;
    assign wb_data   = (opcode == OP_LW) ? data_mem : ula_result;

    // No request in the first cycle after reset: the port stays quiet until the core is running.
    assign mem_req   = started && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we    = (state == S_MEM) && (opcode == OP_SW);
    assign mem_addr  = (state == S_MEM) ? ula_result[MEM_ADDR_W-1:0] : pc[MEM_ADDR_W-1:0];
    assign mem_wdata = b_q;
    assign halted    = (state == S_HALT);

    assign mem_accept   = mem_req && mem_ready;
    assign wait_expired = (MEM_WAIT_MAX != 0) && mem_req && !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R:                              op_legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_y = a_q + imm_sext;
        case (opcode)
            OP_R: begin
                case (funct)
                    FN_SUB:  alu_y = a_q - b_q;
                    FN_AND:  alu_y = a_q & b_q;
                    FN_OR:   alu_y = a_q | b_q;
                    FN_SLT:  alu_y = {31'd0, $signed(a_q) < $signed(b_q)};
                    default: alu_y = a_q + b_q;
                endcase
            end
            OP_BEQ:  alu_y = a_q - b_q;
            OP_J:    alu_y = jump_pc;
            default: alu_y = a_q + imm_sext;
        endcase
    end

    always_comb begin
        next_state = state;
        next_fault = fault;
        case (state)
            S_FETCH: begin
                if (mem_accept) begin
                    next_state = S_DECODE;
                end else if (wait_expired) begin
                    next_state = S_HALT;
                    next_fault = FAULT_BUS;
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_HALT;
                    next_fault = FAULT_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LW, OP_SW: begin
                        if (alu_y[1:0] != 2'b00) begin
                            next_state = S_HALT;
                            next_fault = FAULT_ALIGN;
                        end else begin
                            next_state = S_MEM;
                        end
                    end
                    OP_BEQ, OP_J: next_state = S_FETCH;
                    default:      next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_accept) begin
                    next_state = (opcode == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    next_state = S_HALT;
                    next_fault = FAULT_BUS;
                end
            end
            S_WB:    next_state = S_FETCH;
            default: next_state = S_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_FETCH;
            fault <= 2'b00;
        end else begin
            state <= next_state;
            fault <= next_fault;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            started    <= 1'b0;
            wait_cnt   <= '0;
            pc         <= PC_RESET;
            ir         <= 32'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            ula_result <= 32'd0;
            data_mem   <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else begin
            started  <= 1'b1;
            wait_cnt <= (mem_req && !mem_ready && !wait_expired) ? wait_cnt + 1'b1 : '0;
            case (state)
                S_FETCH: begin
                    if (mem_accept) ir <= mem_rdata;
                end
                S_DECODE: begin
                    a_q <= rf[rs];
                    b_q <= rf[rt];
                end
                S_EXEC: begin
                    ula_result <= alu_y;
                    if (opcode == OP_BEQ) pc <= (a_q == b_q) ? branch_pc : pc_plus4;
                    if (opcode == OP_J)   pc <= jump_pc;
                end
                S_MEM: begin
                    if (mem_accept) begin
                        if (opcode == OP_LW) begin
                            data_mem <= mem_rdata;
                        end else begin
                            data_mem <= b_q;
                            pc       <= pc_plus4;
                        end
                    end
                end
                S_WB: begin
                    // $0 is never written, so reads of it stay zero.
                    if (wr_idx != 5'd0) rf[wr_idx] <= wb_data;
                    pc <= pc_plus4;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - table, directed and random-program checks for mips_multicycle
`timescale 1ns/1ps
module tb_mips_multicycle;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] ula_result;
    logic [31:0] data_mem;
    logic        halted;
    logic [1:0]  fault;

    mips_multicycle #(.PC_RESET(32'h0), .MEM_ADDR_W(32), .MEM_WAIT_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .ula_result(ula_result), .data_mem(data_mem),
        .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] LOOP = 32'h1000_FFFF;

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [1:0]  exp_fault;
    } alu_vec_t;

    alu_vec_t    vecs [11];
    logic [31:0] mem [256];
    logic [31:0] m_prog [64];
    logic [31:0] m_reg [8];
    logic [31:0] m_dmem [16];
    logic [5:0]  fn_tab [5];
    int          req_cycles = 0;
    int          cur_delay = 0;
    bit          rand_delay = 0;
    bit          hold_ready = 0;
    bit          spurious_ready = 0;
    int          total = 0;
    int          bad = 0;

    // Memory responder: ready after cur_delay low cycles of a request.
    always @(negedge clock) begin
        if (mem_req) begin
            mem_ready = !hold_ready && (req_cycles >= cur_delay);
            if (mem_ready) begin
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                req_cycles = 0;
                if (rand_delay) cur_delay = $urandom_range(0, 3);
            end else begin
                mem_rdata = 32'hDEAD_BEEF;
                req_cycles++;
            end
        end else begin
            mem_ready = spurious_ready;
            mem_rdata = 32'hFC00_0000;
            req_cycles = 0;
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hold_ready = 0;
        spurious_ready = 0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic wait_pc(input string name, input logic [31:0] target, input int budget);
        int n;
        n = 0;
        while (pc !== target && !halted && n < budget) begin
            step(1);
            n++;
        end
        chk(name, pc, target);
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(halted), 32'd1);
    endtask

    task automatic gen_prog(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            logic [4:0] rs;
            logic [4:0] rt;
            logic [4:0] rd;
            logic [15:0] imm;
            k   = $urandom_range(0, 9);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            imm = 16'($urandom);
            if (k == 8 && i > n - 2) k = 0;
            case (k)
                0, 1, 2: m_prog[i] = enc_i(6'h08, rs, rt, imm);
                6:       m_prog[i] = enc_i(6'h2B, 5'd0, rt, 16'h0100 + 16'(4 * $urandom_range(0, 15)));
                7:       m_prog[i] = enc_i(6'h23, 5'd0, rt, 16'h0100 + 16'(4 * $urandom_range(0, 15)));
                8:       m_prog[i] = enc_i(6'h04, rs, rt, 16'd1);
                default: m_prog[i] = enc_r(fn_tab[$urandom_range(0, 4)], rs, rt, rd);
            endcase
        end
        m_prog[n] = LOOP;
    endtask

    // Instruction-level interpreter of the program held in m_prog.
    task automatic model_run(input int loop_idx);
        int idx;
        int nidx;
        int guard;
        logic [31:0] ins;
        logic [31:0] simm;
        logic [31:0] res;
        logic [31:0] addr;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        idx = 0;
        guard = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
        while (idx != loop_idx && guard < 200) begin
            ins  = m_prog[idx];
            rs   = ins[23:21];
            rt   = ins[18:16];
            rd   = ins[13:11];
            simm = {{16{ins[15]}}, ins[15:0]};
            addr = m_reg[rs] + simm;
            nidx = idx + 1;
            case (ins[31:26])
                6'h08: if (rt != 0) m_reg[rt] = m_reg[rs] + simm;
                6'h23: if (rt != 0) m_reg[rt] = m_dmem[(addr - 32'h100) >> 2];
                6'h2B: m_dmem[(addr - 32'h100) >> 2] = m_reg[rt];
                6'h04: if (m_reg[rs] == m_reg[rt]) nidx = idx + 1 + int'($signed(simm));
                default: begin
                    case (ins[5:0])
                        6'h20:   res = m_reg[rs] + m_reg[rt];
                        6'h22:   res = m_reg[rs] - m_reg[rt];
                        6'h24:   res = m_reg[rs] & m_reg[rt];
                        6'h25:   res = m_reg[rs] | m_reg[rt];
                        default: res = ($signed(m_reg[rs]) < $signed(m_reg[rt])) ? 32'd1 : 32'd0;
                    endcase
                    if (rd != 0) m_reg[rd] = res;
                end
            endcase
            idx = nidx;
            guard++;
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        int fetches;
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        vecs[0]  = '{6'h20, 32'd5,         32'd7,         32'd12,        2'b00};
        vecs[1]  = '{6'h20, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 2'b00};
        vecs[2]  = '{6'h22, 32'd0,         32'd1,         32'hFFFF_FFFF, 2'b00};
        vecs[3]  = '{6'h22, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 2'b00};
        vecs[4]  = '{6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 2'b00};
        vecs[5]  = '{6'h25, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 2'b00};
        vecs[6]  = '{6'h2A, 32'hFFFF_FFFF, 32'd1,         32'd1,         2'b00};
        vecs[7]  = '{6'h2A, 32'd1,         32'hFFFF_FFFF, 32'd0,         2'b00};
        vecs[8]  = '{6'h2A, 32'd3,         32'd3,         32'd0,         2'b00};
        vecs[9]  = '{6'h21, 32'd1,         32'd2,         32'd0,         2'b01};
        vecs[10] = '{6'h00, 32'd1,         32'd2,         32'd0,         2'b01};

        // Reset values, then addi/addi/add with zero-wait memory.
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        mem[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
        mem[3] = LOOP;
        cur_delay = 0;
        reset = 1'b0;
        step(2);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ula", ula_result, 32'd0);
        chk("rst_data_mem", data_mem, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        reset = 1'b1;
        step(1);
        chk("first_fetch_req", 32'(mem_req), 32'd1);
        chk("first_fetch_addr", mem_addr, 32'd0);
        chk("first_fetch_we", 32'(mem_we), 32'd0);
        step(12);
        chk("add3_pc", pc, 32'h0C);
        chk("add3_ula", ula_result, 32'd12);
        chk("add3_r3", dut.rf[3], 32'd12);

        // Reset mid-request clears the register file and drops the request.
        reset = 1'b0;
        step(1);
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_r3_cleared", dut.rf[3], 32'd0);
        chk("rst_mid_pc", pc, 32'd0);

        // sw with a 3-cycle ready delay, then lw back.
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'd4);
        mem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd4);
        mem[3] = LOOP;
        rand_delay = 0;
        cur_delay = 3;
        do_reset();
        reqs = 0;
        while (!(mem_req && mem_we) && reqs < 100) begin
            step(1);
            reqs++;
        end
        chk("sw_seen", 32'(mem_we), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("sw_wdata_stable", mem_wdata, 32'd12);
            chk("sw_addr_stable", mem_addr, 32'd4);
            chk("sw_req_held", 32'(mem_req), 32'd1);
            step(1);
        end
        chk("after_sw_we", 32'(mem_we), 32'd0);
        chk("after_sw_pc", pc, 32'd8);
        wait_pc("lw_done_pc", 32'h0C, 200);
        chk("lw_r4", dut.rf[4], 32'd12);
        chk("lw_data_mem", data_mem, 32'd12);
        chk("sw_mem_word", mem[1], 32'd12);

        // beq not taken, then branch-to-self.
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd4);
        mem[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        mem[3] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        cur_delay = 0;
        do_reset();
        wait_pc("beq_not_taken_pc", 32'h0C, 100);
        fetches = 0;
        for (int k = 0; k < 9; k++) begin
            chk("beq_self_pc", pc, 32'h0C);
            if (mem_req) fetches++;
            step(1);
        end
        chk("beq_self_fetches", 32'(fetches), 32'd3);

        // Misaligned load halts without a data request.
        clear_mem();
        mem[0] = enc_i(6'h23, 5'd0, 5'd5, 16'd2);
        cur_delay = 0;
        do_reset();
        reqs = 0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (mem_req) reqs++;
        end
        chk("misalign_reqs", 32'(reqs), 32'd1);
        chk("misalign_halted", 32'(halted), 32'd1);
        chk("misalign_fault", 32'(fault), 32'd2);
        chk("misalign_pc", pc, 32'd0);
        chk("misalign_r5", dut.rf[5], 32'd0);

        // Illegal opcode.
        clear_mem();
        mem[0] = 32'hFC00_0000;
        do_reset();
        step(6);
        chk("illegal_halted", 32'(halted), 32'd1);
        chk("illegal_fault", 32'(fault), 32'd1);
        chk("illegal_req", 32'(mem_req), 32'd0);

        // Bus timeout after four waiting request cycles.
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
        do_reset();
        hold_ready = 1;
        step(4);
        chk("timeout_not_yet", 32'(halted), 32'd0);
        chk("timeout_req_held", 32'(mem_req), 32'd1);
        step(1);
        chk("timeout_halted", 32'(halted), 32'd1);
        chk("timeout_fault", 32'(fault), 32'd3);
        chk("timeout_req_drop", 32'(mem_req), 32'd0);
        step(3);
        chk("timeout_frozen_fault", 32'(fault), 32'd3);
        chk("timeout_frozen_pc", pc, 32'd0);

        // Reset during a stalled fetch, with a late ready ignored.
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
        mem[2] = LOOP;
        do_reset();
        wait_pc("stall_pre_pc", 32'd4, 50);
        hold_ready = 1;
        step(2);
        chk("stall_req", 32'(mem_req), 32'd1);
        reset = 1'b0;
        step(1);
        chk("stall_rst_req", 32'(mem_req), 32'd0);
        chk("stall_rst_pc", pc, 32'd0);
        hold_ready = 0;
        spurious_ready = 1;
        reset = 1'b1;
        step(1);
        spurious_ready = 0;
        chk("clean_fetch_req", 32'(mem_req), 32'd1);
        chk("clean_fetch_addr", mem_addr, 32'd0);
        wait_pc("after_rst_pc", 32'd8, 60);
        chk("after_rst_r1", dut.rf[1], 32'd9);
        chk("after_rst_fault", 32'(fault), 32'd0);

        // ALU vector table: operands loaded from memory, result stored back.
        rand_delay = 1;
        for (int v = 0; v < 11; v++) begin
            clear_mem();
            mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h0100);
            mem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h0104);
            mem[2] = enc_r(vecs[v].fn, 5'd1, 5'd2, 5'd3);
            mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0108);
            mem[4] = LOOP;
            mem[8'h40] = vecs[v].a;
            mem[8'h41] = vecs[v].b;
            mem[8'h42] = 32'hA5A5_A5A5;
            do_reset();
            if (vecs[v].exp_fault == 2'b00) begin
                wait_pc($sformatf("alu%0d_end_pc", v), 32'h10, 400);
                chk($sformatf("alu%0d_stored", v), mem[8'h42], vecs[v].exp);
                chk($sformatf("alu%0d_r3", v), dut.rf[3], vecs[v].exp);
                chk($sformatf("alu%0d_fault", v), 32'(fault), 32'd0);
            end else begin
                wait_halt($sformatf("alu%0d_halted", v), 400);
                chk($sformatf("alu%0d_fault", v), 32'(fault), 32'(vecs[v].exp_fault));
                chk($sformatf("alu%0d_pc", v), pc, 32'd8);
            end
        end

        // Random programs against the instruction-level model.
        for (int p = 0; p < 4; p++) begin
            clear_mem();
            gen_prog(24);
            for (int i = 0; i <= 24; i++) mem[i] = m_prog[i];
            for (int j = 0; j < 16; j++) begin
                m_dmem[j] = $urandom;
                mem[8'h40 + j] = m_dmem[j];
            end
            model_run(24);
            cur_delay = $urandom_range(0, 3);
            do_reset();
            wait_pc($sformatf("rnd%0d_end_pc", p), 32'(24 * 4), 3000);
            chk($sformatf("rnd%0d_fault", p), 32'(fault), 32'd0);
            chk($sformatf("rnd%0d_r0", p), dut.rf[0], 32'd0);
            for (int r = 1; r < 8; r++) chk($sformatf("rnd%0d_r%0d", p, r), dut.rf[r], m_reg[r]);
            for (int j = 0; j < 16; j++) chk($sformatf("rnd%0d_dmem%0d", p, j), mem[8'h40 + j], m_dmem[j]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
